// File: rtl/interval_meter.sv
// interval_meter: counts clock cycles from a START pulse to a STOP pulse.
// Ports: CLK, RST (async, active-high), START, STOP, ACK in;
//        BUSY, VALID, INTERVAL[CNT_W], TIMEOUT, OVERRUN out (all registered).
module interval_meter #(
    parameter int CNT_W     = 21,
    parameter int TIMEOUT_C = 2**21 - 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             ACK,
    output logic             BUSY,
    output logic             VALID,
    output logic [CNT_W-1:0] INTERVAL,
    output logic             TIMEOUT,
    output logic             OVERRUN
);

    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_C);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            BUSY     <= 1'b0;
            VALID    <= 1'b0;
            INTERVAL <= '0;
            TIMEOUT  <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // START wins over a simultaneous STOP
                    if (START) begin
                        state <= MEASURE;
                        cnt   <= ONE;
                        BUSY  <= 1'b1;
                    end
                end
                MEASURE: begin
                    // STOP beats the timeout on the same cycle
                    if (STOP) begin
                        INTERVAL <= cnt;
                        TIMEOUT  <= 1'b0;
                        state    <= HOLD;
                        BUSY     <= 1'b0;
                        VALID    <= 1'b1;
                    end else if (cnt == TO_MAX) begin
                        INTERVAL <= TO_MAX;
                        TIMEOUT  <= 1'b1;
                        state    <= HOLD;
                        BUSY     <= 1'b0;
                        VALID    <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HOLD: begin
                    if (ACK) begin
                        VALID   <= 1'b0;
                        OVERRUN <= 1'b0;
                        // ACK with START chains straight into a new run
                        if (START) begin
                            state <= MEASURE;
                            cnt   <= ONE;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (START) begin
                        OVERRUN <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: scoreboard bench for interval_meter (CNT_W=8, TIMEOUT_C=16).
// Expected results are queued when stimulus is driven and popped on VALID.
module tb_interval_meter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       ACK = 1'b0;
    logic       BUSY;
    logic       VALID;
    logic [7:0] INTERVAL;
    logic       TIMEOUT;
    logic       OVERRUN;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] iv;
        logic       to;
    } exp_t;

    exp_t q[$];

    interval_meter #(.CNT_W(8), .TIMEOUT_C(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .ACK(ACK),
        .BUSY(BUSY), .VALID(VALID), .INTERVAL(INTERVAL),
        .TIMEOUT(TIMEOUT), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // one clock edge with the given inputs sampled, then settle 1 time unit
    task automatic pulse(input logic s, input logic p, input logic a);
        START = s; STOP = p; ACK = a;
        @(posedge CLK); #1;
        START = 0; STOP = 0; ACK = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic push(input logic [7:0] iv, input logic to);
        exp_t e;
        e.iv = iv; e.to = to;
        q.push_back(e);
    endtask

    // bounded wait for VALID, then pop the expected entry
    task automatic take(output bit ok, output exp_t e);
        ok = 0;
        e.iv = 'x; e.to = 'x;
        for (int i = 0; i < 40; i++) begin
            if (VALID === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge CLK); #1;
        end
        if (q.size() == 0) ok = 0;
        else e = q.pop_front();
    endtask

    task automatic test_reset;
        RST = 1; #2;
        total++;
        if ({BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN} !== 12'd0) begin
            bad++;
            $display("FAIL reset: got b=%b v=%b iv=%0d t=%b o=%b want all 0",
                     BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN);
        end
        @(posedge CLK); #1;
        RST = 0;
        idle(1);
    endtask

    task automatic test_basic;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        total++;
        if (BUSY !== 1'b1 || VALID !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: got b=%b v=%b want b=1 v=0", BUSY, VALID);
        end
        idle(4);
        push(8'd5, 1'b0);
        pulse(0, 1, 0);
        total++;
        if (VALID !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency: got v=%b b=%b want v=1 b=0", VALID, BUSY);
        end
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL basic_result: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        idle(3);
        pulse(0, 0, 1);
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b0 || INTERVAL !== 8'd5) begin
            bad++;
            $display("FAIL basic_ack: got v=%b b=%b iv=%0d want v=0 b=0 iv=5",
                     VALID, BUSY, INTERVAL);
        end
    endtask

    task automatic test_min;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        push(8'd1, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL min_interval: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
        pulse(1, 1, 0);
        total++;
        if (BUSY !== 1'b1 || VALID !== 1'b0) begin
            bad++;
            $display("FAIL idle_start_stop: got b=%b v=%b want b=1 v=0", BUSY, VALID);
        end
        idle(2);
        push(8'd3, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL idle_start_stop_iv: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
    endtask

    task automatic test_timeout;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        idle(15);
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got v=%b b=%b want v=0 b=1", VALID, BUSY);
        end
        push(8'd16, 1'b1);
        idle(1);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL timeout_result: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        idle(15);
        push(8'd16, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL stop_at_limit: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
    endtask

    task automatic test_hold;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        idle(1);
        push(8'd2, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL hold_result: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        total++;
        if (OVERRUN !== 1'b1 || VALID !== 1'b1 || INTERVAL !== 8'd2 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL overrun: got o=%b v=%b iv=%0d b=%b want o=1 v=1 iv=2 b=0",
                     OVERRUN, VALID, INTERVAL, BUSY);
        end
        pulse(0, 0, 1);
        total++;
        if (OVERRUN !== 1'b0 || VALID !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got o=%b v=%b want o=0 v=0", OVERRUN, VALID);
        end
    endtask

    task automatic test_back_to_back;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        push(8'd1, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL b2b_first: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(1, 0, 1);
        total++;
        if (BUSY !== 1'b1 || VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            bad++;
            $display("FAIL b2b_rearm: got b=%b v=%b o=%b want b=1 v=0 o=0",
                     BUSY, VALID, OVERRUN);
        end
        idle(2);
        push(8'd3, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL b2b_second: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
    endtask

    task automatic test_ignored;
        bit ok; exp_t e;
        pulse(0, 1, 0);
        idle(2);
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b0 || INTERVAL !== 8'd3) begin
            bad++;
            $display("FAIL idle_stop: got v=%b b=%b iv=%0d want v=0 b=0 iv=3",
                     VALID, BUSY, INTERVAL);
        end
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        idle(2);
        push(8'd5, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL measure_start_ignored: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
    endtask

    task automatic test_mid_reset;
        bit ok; exp_t e;
        pulse(1, 0, 0);
        idle(3);
        #2 RST = 1;
        #1;
        total++;
        if ({BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN} !== 12'd0) begin
            bad++;
            $display("FAIL reset_measure: got b=%b v=%b iv=%0d t=%b o=%b want all 0",
                     BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN);
        end
        @(posedge CLK); #1;
        RST = 0;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        #2 RST = 1;
        #1;
        total++;
        if ({BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN} !== 12'd0) begin
            bad++;
            $display("FAIL reset_hold: got b=%b v=%b iv=%0d t=%b o=%b want all 0",
                     BUSY, VALID, INTERVAL, TIMEOUT, OVERRUN);
        end
        @(posedge CLK); #1;
        RST = 0;
        pulse(0, 1, 0);
        idle(2);
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_stop: got v=%b b=%b want v=0 b=0", VALID, BUSY);
        end
        pulse(1, 0, 0);
        idle(6);
        push(8'd7, 1'b0);
        pulse(0, 1, 0);
        take(ok, e);
        total++;
        if (!ok || INTERVAL !== e.iv || TIMEOUT !== e.to) begin
            bad++;
            $display("FAIL post_reset_iv: got iv=%0d t=%b want iv=%0d t=%b",
                     INTERVAL, TIMEOUT, e.iv, e.to);
        end
        pulse(0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_ignored();
        test_mid_reset();
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
